// File: rtl/layer_serializer_if.sv
// layer_serializer_if: parallel neuron results in, one-value-per-transfer stream out
interface layer_serializer_if #(
  parameter int NUM_VALUES = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1
);
  logic [NUM_VALUES*WIDTH-1:0] VALUES_IN;
  logic [NUM_VALUES-1:0] VALIDS_IN;
  logic OVERFLOW_IN;
  logic COLLECTING;
  logic signed [WIDTH-1:0] VALUE_OUT;
  logic VALID_OUT;
  logic READY_IN;
  logic LAST_OUT;
  logic [IDX_W-1:0] INDEX_OUT;
  logic OVF_OUT;
  logic OVERRUN;
  modport slave (
    input VALUES_IN, VALIDS_IN, OVERFLOW_IN, READY_IN,
    output COLLECTING, VALUE_OUT, VALID_OUT, LAST_OUT, INDEX_OUT, OVF_OUT, OVERRUN
  );
  modport master (
    output VALUES_IN, VALIDS_IN, OVERFLOW_IN, READY_IN,
    input COLLECTING, VALUE_OUT, VALID_OUT, LAST_OUT, INDEX_OUT, OVF_OUT, OVERRUN
  );
endinterface

// File: rtl/layer_serializer.sv
// layer_serializer: collects per-neuron results, then streams them in index order; LAYER_SERIALIZER_PINGPONG_EN adds a second bank
module layer_serializer #(
  parameter int NUM_VALUES = 4,
  parameter int WIDTH = 8,
  parameter int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1
) (
  input logic CLK,
  input logic RST,
  layer_serializer_if.slave bus
);
`ifdef LAYER_SERIALIZER_PINGPONG_EN
  localparam logic TOG = 1'b1;
`else
  localparam logic TOG = 1'b0;
`endif
  logic [WIDTH-1:0] data [2][NUM_VALUES];
  logic [NUM_VALUES-1:0] mask [2];
  logic [1:0] full, acc, tag;
  logic wb, sb, nb, valid, ovf, overrun;
  logic [IDX_W-1:0] idx;
  logic [NUM_VALUES-1:0] mask_nx;
  logic acc_nx, xfer, last, fin, cap, done, start;
  assign xfer = valid & bus.READY_IN;
  assign last = idx == IDX_W'(NUM_VALUES - 1);
  assign fin = xfer & last;
  // a bank whose final element leaves this cycle already accepts the next vector
  assign cap = !full[wb] | (fin & (sb == wb));
  assign mask_nx = mask[wb] | bus.VALIDS_IN;
  assign acc_nx = acc[wb] | bus.OVERFLOW_IN;
  // completion needs a bank that was free at the start of the cycle, giving the 1+N minimum period
  assign done = !full[wb] & (&mask_nx);
  assign start = (!valid | fin) & ((full[nb] & !(fin & (sb == nb))) | (done & (wb == nb)));
  assign bus.COLLECTING = !full[wb];
  assign bus.VALID_OUT = valid;
  assign bus.VALUE_OUT = valid ? data[sb][idx] : '0;
  assign bus.LAST_OUT = valid & last;
  assign bus.INDEX_OUT = idx;
  assign bus.OVF_OUT = ovf;
  assign bus.OVERRUN = overrun;
  // store each arriving slot into the collecting bank; contents need no reset
  always_ff @(posedge CLK)
    if (cap)
      for (int i = 0; i < NUM_VALUES; i++)
        if (bus.VALIDS_IN[i]) data[wb][i] <= bus.VALUES_IN[i*WIDTH +: WIDTH];
  // collect/stream control: masks, overflow tags, bank queueing and stream index
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask <= '{default: '0};
      full <= '0;
      acc <= '0;
      tag <= '0;
      wb <= 1'b0;
      sb <= 1'b0;
      nb <= 1'b0;
      idx <= '0;
      valid <= 1'b0;
      ovf <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (cap) begin
        mask[wb] <= mask_nx;
        acc[wb] <= acc_nx;
      end
      if ((|bus.VALIDS_IN) && !cap) overrun <= 1'b1;
      if (xfer) idx <= last ? '0 : idx + IDX_W'(1);
      if (fin) begin
        full[sb] <= 1'b0;
        valid <= 1'b0;
      end
      if (done) begin
        full[wb] <= 1'b1;
        mask[wb] <= '0;
        acc[wb] <= 1'b0;
        tag[wb] <= acc_nx;
        wb <= wb ^ TOG;
      end
      if (start) begin
        valid <= 1'b1;
        idx <= '0;
        sb <= nb;
        nb <= nb ^ TOG;
        ovf <= (done && (wb == nb)) ? acc_nx : tag[nb];
      end
    end
  end
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: table-driven directed vectors plus latency/backpressure sequence
module tb_layer_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  layer_serializer_if #(.NUM_VALUES(4), .WIDTH(8)) bus ();
  layer_serializer #(.NUM_VALUES(4), .WIDTH(8)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));
  typedef struct {
    string tag;
    logic r, rd, o;
    logic [3:0] v;
    logic [31:0] d;
    logic ev;
    logic [7:0] ex;
    logic [1:0] ei;
    logic el, ec, eo, er;
  } vec_t;
  vec_t tbl[$];
  int tests = 0;
  int fails = 0;
  function automatic logic [31:0] pk(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction
  task automatic add(string t, logic r, logic rd, logic o, logic [3:0] v, logic [31:0] d,
                     logic ev, int ex, int ei, logic el, logic ec, logic eo, logic er);
    vec_t x;
    x.tag = t; x.r = r; x.rd = rd; x.o = o; x.v = v; x.d = d;
    x.ev = ev; x.ex = ex[7:0]; x.ei = ei[1:0]; x.el = el; x.ec = ec; x.eo = eo; x.er = er;
    tbl.push_back(x);
  endtask
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] g, v1, v2, v3;
    logic [14:0] act, exp;
    int lat, n;
    g = pk(85, 85, 85, 85);
    v1 = pk(10, -3, 7, -128);
    v2 = pk(5, -1, 127, -7);
    v3 = pk(-2, 9, -9, 64);
    bus.VALUES_IN = '0;
    bus.VALIDS_IN = '0;
    bus.OVERFLOW_IN = 1'b0;
    bus.READY_IN = 1'b0;
    add("reset", 1, 0, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
`ifdef LAYER_SERIALIZER_PINGPONG_EN
    add("pp_a", 0, 1, 0, 4'b1111, pk(1, 2, 3, 4), 1, 1, 0, 0, 1, 0, 0);
    add("pp_b", 0, 1, 0, 4'b1111, pk(5, 6, 7, 8), 1, 2, 1, 0, 0, 0, 0);
    add("pp_a2", 0, 1, 0, 4'b0000, g, 1, 3, 2, 0, 0, 0, 0);
    add("pp_a3", 0, 1, 0, 4'b0000, g, 1, 4, 3, 1, 0, 0, 0);
    add("pp_b0", 0, 1, 0, 4'b0000, g, 1, 5, 0, 0, 1, 0, 0);
    add("pp_b1", 0, 1, 0, 4'b0000, g, 1, 6, 1, 0, 1, 0, 0);
    add("pp_b2", 0, 1, 0, 4'b0000, g, 1, 7, 2, 0, 1, 0, 0);
    add("pp_b3", 0, 1, 0, 4'b0000, g, 1, 8, 3, 1, 1, 0, 0);
    add("pp_end", 0, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
`else
    add("a_c0", 0, 1, 0, 4'b0001, v1, 0, 0, 0, 0, 1, 0, 0);
    add("a_c1", 0, 1, 0, 4'b0100, v1, 0, 0, 0, 0, 1, 0, 0);
    add("a_c2", 0, 1, 0, 4'b0000, v1, 0, 0, 0, 0, 1, 0, 0);
    add("a_c3", 0, 1, 0, 4'b0010, v1, 0, 0, 0, 0, 1, 0, 0);
    add("a_c4", 0, 1, 0, 4'b0000, v1, 0, 0, 0, 0, 1, 0, 0);
    add("a_c5", 0, 1, 0, 4'b1000, v1, 1, 10, 0, 0, 0, 0, 0);
    add("a_e1", 0, 1, 0, 4'b0000, g, 1, -3, 1, 0, 0, 0, 0);
    add("a_e2", 0, 1, 0, 4'b0000, g, 1, 7, 2, 0, 0, 0, 0);
    add("a_e3", 0, 1, 0, 4'b0000, g, 1, -128, 3, 1, 0, 0, 0);
    add("a_end", 0, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
    add("b_c0", 0, 1, 1, 4'b0011, v2, 0, 0, 0, 0, 1, 0, 0);
    add("b_c1", 0, 0, 0, 4'b1100, v2, 1, 5, 0, 0, 0, 1, 0);
    add("b_r1a", 0, 1, 0, 4'b0000, g, 1, -1, 1, 0, 0, 1, 0);
    add("b_r0a", 0, 0, 0, 4'b0000, g, 1, -1, 1, 0, 0, 1, 0);
    add("b_r0b", 0, 0, 0, 4'b0000, g, 1, -1, 1, 0, 0, 1, 0);
    add("b_r1b", 0, 1, 0, 4'b0000, g, 1, 127, 2, 0, 0, 1, 0);
    add("b_r0c", 0, 0, 0, 4'b0000, g, 1, 127, 2, 0, 0, 1, 0);
    add("b_r1c", 0, 1, 0, 4'b0000, g, 1, -7, 3, 1, 0, 1, 0);
    add("b_end", 0, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
    add("c_c0", 0, 1, 0, 4'b1111, v3, 1, -2, 0, 0, 0, 0, 0);
    add("c_e1", 0, 1, 0, 4'b0000, g, 1, 9, 1, 0, 0, 0, 0);
    add("c_e2", 0, 1, 0, 4'b0000, g, 1, -9, 2, 0, 0, 0, 0);
    add("c_e3", 0, 1, 0, 4'b0000, g, 1, 64, 3, 1, 0, 0, 0);
    add("c_fin_v2", 0, 1, 0, 4'b0100, pk(0, 0, 33, 0), 0, 0, 0, 0, 1, 0, 0);
    add("d_c0", 0, 1, 0, 4'b1011, pk(11, 22, 99, 44), 1, 11, 0, 0, 0, 0, 0);
    add("d_e1", 0, 1, 0, 4'b0000, g, 1, 22, 1, 0, 0, 0, 0);
    add("d_ovr", 0, 1, 0, 4'b0100, pk(0, 0, 77, 0), 1, 33, 2, 0, 0, 0, 1);
    add("d_e3", 0, 1, 0, 4'b0000, g, 1, 44, 3, 1, 0, 0, 1);
    add("d_end", 0, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 1);
    add("e_c0", 0, 1, 0, 4'b1111, pk(1, 2, 3, 4), 1, 1, 0, 0, 0, 0, 1);
    add("e_e1", 0, 1, 0, 4'b0000, g, 1, 2, 1, 0, 0, 0, 1);
    add("e_e2", 0, 1, 0, 4'b0000, g, 1, 3, 2, 0, 0, 0, 1);
    add("e_rst", 1, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
    add("f_idle", 0, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
    add("f_c0", 0, 1, 0, 4'b0111, pk(8, 8, 8, 8), 0, 0, 0, 0, 1, 0, 0);
    add("f_c1", 0, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
    add("f_c2", 0, 1, 0, 4'b1000, pk(0, 0, 0, -1), 1, 8, 0, 0, 0, 0, 0);
    add("f_e1", 0, 1, 0, 4'b0000, g, 1, 8, 1, 0, 0, 0, 0);
    add("f_e2", 0, 1, 0, 4'b0000, g, 1, 8, 2, 0, 0, 0, 0);
    add("f_e3", 0, 1, 0, 4'b0000, g, 1, -1, 3, 1, 0, 0, 0);
    add("f_fin_all", 0, 1, 0, 4'b1111, pk(3, 1, 4, 1), 0, 0, 0, 0, 1, 0, 0);
    add("g_gap", 0, 1, 0, 4'b0000, g, 1, 3, 0, 0, 0, 0, 0);
    add("g_e1", 0, 1, 0, 4'b0000, g, 1, 1, 1, 0, 0, 0, 0);
    add("g_e2", 0, 1, 0, 4'b0000, g, 1, 4, 2, 0, 0, 0, 0);
    add("g_e3", 0, 1, 0, 4'b0000, g, 1, 1, 3, 1, 0, 0, 0);
    add("g_end", 0, 1, 0, 4'b0000, g, 0, 0, 0, 0, 1, 0, 0);
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      bus.READY_IN = tbl[i].rd;
      bus.OVERFLOW_IN = tbl[i].o;
      bus.VALIDS_IN = tbl[i].v;
      bus.VALUES_IN = tbl[i].d;
      step();
      act = {bus.VALID_OUT, bus.LAST_OUT, bus.COLLECTING, bus.OVERRUN,
             tbl[i].ev ? {bus.VALUE_OUT, bus.INDEX_OUT, bus.OVF_OUT} : 11'b0};
      exp = {tbl[i].ev, tbl[i].el, tbl[i].ec, tbl[i].er,
             tbl[i].ev ? {tbl[i].ex, tbl[i].ei, tbl[i].eo} : 11'b0};
      chk(tbl[i].tag, {17'b0, act}, {17'b0, exp});
    end
    rst = 1'b1;
    bus.VALIDS_IN = '0;
    bus.READY_IN = 1'b0;
    step();
    rst = 1'b0;
    bus.VALIDS_IN = 4'b1111;
    bus.VALUES_IN = pk(-5, 6, -7, 8);
    step();
    bus.VALIDS_IN = '0;
    bus.VALUES_IN = g;
    lat = 0;
    while (!bus.VALID_OUT && lat < 4) begin
      step();
      lat++;
    end
    chk("latency", lat, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold", {21'b0, bus.VALUE_OUT, bus.INDEX_OUT, bus.VALID_OUT}, {21'b0, 8'hFB, 2'd0, 1'b1});
    end
    bus.READY_IN = 1'b1;
    n = 0;
    while (!bus.LAST_OUT && n < 8) begin
      step();
      n++;
    end
    chk("last_after", n, 3);
    chk("last_val", {24'b0, bus.VALUE_OUT}, 32'h08);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
